// File: rtl/rx_lbuf_tlp_wr.sv
// rx_lbuf_tlp_wr: fills a granted host lbuf with posted Memory Write TLPs.
//
// Takes the lbuf granted on lbuf_en/lbuf_addr/lbuf64b and writes it as NTLP
// back-to-back MWr TLPs of MAX_PAYLOAD_DW each. Payload comes from a
// show-ahead qword FIFO. lbuf_dn pulses once the whole lbuf has been written.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   lbuf_addr/en/64b  lbuf grant (base, level-valid, 4DW header select)
//   lbuf_dn           one-cycle pulse, lbuf fully written
//   src_data          show-ahead qword, [63:32] is the first DW
//   src_qw_avail      qwords available in the source
//   src_rd_en         pops one qword (combinational, qualified by beat accept)
//   cfg_completer_id  requester ID for header DW1
//   trn_*             TRN tx interface (active-low strobes, registered)
module rx_lbuf_tlp_wr #(
    parameter int unsigned MAX_PAYLOAD_DW = 32,
    parameter int unsigned LBUF_BYTES     = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] lbuf_addr,
    input  logic        lbuf_en,
    input  logic        lbuf64b,
    output logic        lbuf_dn,
    input  logic [63:0] src_data,
    input  logic [9:0]  src_qw_avail,
    output logic        src_rd_en,
    input  logic [15:0] cfg_completer_id,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    output logic        trn_tsrc_dsc_n,
    input  logic        trn_tdst_rdy_n
);

    localparam int unsigned QW   = MAX_PAYLOAD_DW / 2;
    localparam int unsigned NTLP = LBUF_BYTES / (MAX_PAYLOAD_DW * 4);
    localparam int unsigned STEP = MAX_PAYLOAD_DW * 4;
    localparam int unsigned QCW  = $clog2(QW + 1);
    localparam int unsigned TCW  = $clog2(NTLP + 1);
    localparam logic [9:0]  LEN  = 10'(MAX_PAYLOAD_DW);
    localparam logic [9:0]  QW10 = 10'(QW);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        HDR0,
        HDR1,
        DATA,
        NEXT,
        DONE,
        WAIT_EN_LOW
    } state_t;

    state_t            state, state_d;
    logic [63:0]       cur_addr, cur_addr_d;
    logic              hdr4, hdr4_d;
    logic [TCW-1:0]    tlp_cnt, tlp_cnt_d;
    logic [QCW-1:0]    qcnt, qcnt_d;
    logic [31:0]       hold, hold_d;
    logic [63:0]       td_d;
    logic [7:0]        trem_n_d;
    logic              tsof_n_d, teof_n_d, tsrc_rdy_n_d, lbuf_dn_d;
    logic              accept;
    logic [31:0]       dw0, dw1;

    assign trn_tsrc_dsc_n = 1'b1;
    assign accept = ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n;
    assign dw0    = (hdr4 ? 32'h6000_0000 : 32'h4000_0000) | {22'h0, LEN};
    assign dw1    = {cfg_completer_id, 8'h00, 8'hFF};

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cur_addr       <= '0;
            hdr4           <= 1'b0;
            tlp_cnt        <= '0;
            qcnt           <= '0;
            hold           <= '0;
            trn_td         <= '0;
            trn_trem_n     <= '0;
            trn_tsof_n     <= 1'b1;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
            lbuf_dn        <= 1'b0;
        end else begin
            state          <= state_d;
            cur_addr       <= cur_addr_d;
            hdr4           <= hdr4_d;
            tlp_cnt        <= tlp_cnt_d;
            qcnt           <= qcnt_d;
            hold           <= hold_d;
            trn_td         <= td_d;
            trn_trem_n     <= trem_n_d;
            trn_tsof_n     <= tsof_n_d;
            trn_teof_n     <= teof_n_d;
            trn_tsrc_rdy_n <= tsrc_rdy_n_d;
            lbuf_dn        <= lbuf_dn_d;
        end
    end

    // Next state, next beat and source pop. A beat register is only reloaded
    // when the current beat is accepted, so stalls hold everything.
    always_comb begin
        state_d      = state;
        cur_addr_d   = cur_addr;
        hdr4_d       = hdr4;
        tlp_cnt_d    = tlp_cnt;
        qcnt_d       = qcnt;
        hold_d       = hold;
        td_d         = trn_td;
        trem_n_d     = trn_trem_n;
        tsof_n_d     = trn_tsof_n;
        teof_n_d     = trn_teof_n;
        tsrc_rdy_n_d = trn_tsrc_rdy_n;
        lbuf_dn_d    = 1'b0;
        src_rd_en    = 1'b0;

        case (state)
            IDLE: begin
                if (lbuf_en) begin
                    cur_addr_d = lbuf_addr;
                    hdr4_d     = lbuf64b;
                    tlp_cnt_d  = '0;
                    state_d    = WAIT_DATA;
                end
            end

            WAIT_DATA: begin
                // Whole TLP payload must be present: no bubbles once started.
                if (src_qw_avail >= QW10) begin
                    td_d         = {dw0, dw1};
                    tsof_n_d     = 1'b0;
                    teof_n_d     = 1'b1;
                    trem_n_d     = 8'h00;
                    tsrc_rdy_n_d = 1'b0;
                    qcnt_d       = '0;
                    state_d      = HDR0;
                end
            end

            HDR0: begin
                if (accept) begin
                    tsof_n_d = 1'b1;
                    state_d  = HDR1;
                    if (hdr4) begin
                        td_d = {cur_addr[63:32], cur_addr[31:2], 2'b00};
                    end else begin
                        // 3DW: first data DW shares the beat with the address.
                        td_d      = {cur_addr[31:2], 2'b00, src_data[63:32]};
                        hold_d    = src_data[31:0];
                        qcnt_d    = QCW'(1);
                        src_rd_en = 1'b1;
                    end
                end
            end

            HDR1, DATA: begin
                if (accept) begin
                    if (!trn_teof_n) begin
                        tsrc_rdy_n_d = 1'b1;
                        teof_n_d     = 1'b1;
                        trem_n_d     = 8'h00;
                        state_d      = NEXT;
                    end else begin
                        state_d = DATA;
                        if (hdr4) begin
                            td_d      = src_data;
                            teof_n_d  = (qcnt != QCW'(QW - 1));
                            qcnt_d    = qcnt + QCW'(1);
                            src_rd_en = 1'b1;
                        end else if (qcnt < QCW'(QW)) begin
                            td_d      = {hold, src_data[63:32]};
                            hold_d    = src_data[31:0];
                            qcnt_d    = qcnt + QCW'(1);
                            src_rd_en = 1'b1;
                        end else begin
                            // Trailing odd DW: only the upper half is valid.
                            td_d     = {hold, 32'h0};
                            trem_n_d = 8'h0F;
                            teof_n_d = 1'b0;
                        end
                    end
                end
            end

            NEXT: begin
                cur_addr_d = cur_addr + 64'(STEP);
                tlp_cnt_d  = tlp_cnt + TCW'(1);
                if (tlp_cnt == TCW'(NTLP - 1)) begin
                    lbuf_dn_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = WAIT_DATA;
                end
            end

            DONE: begin
                state_d = WAIT_EN_LOW;
            end

            WAIT_EN_LOW: begin
                // A grant held high must drop before another fill can start.
                if (!lbuf_en) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
